// File: rtl/npu_result_drain.sv
// Captures the eight NPU result streams after save_finish rises, then replays
// them as one sop/data/eop packet per channel on a 32-bit stream with backpressure.
module npu_result_drain #(
  parameter int NUM_CH  = 8,
  parameter int DW      = 16,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 save_finish,
  output logic [NUM_CH-1:0]    rd_sop_o,
  input  logic [NUM_CH-1:0]    rd_vld_i,
  input  logic [NUM_CH-1:0]    rd_eop_i,
  input  logic [NUM_CH*DW-1:0] rd_data_i,
  output logic                 out_sop,
  output logic                 out_vld,
  output logic [2*DW-1:0]      out_data,
  output logic                 out_eop,
  output logic [2:0]           out_ch,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic                 drain_done,
  output logic [NUM_CH-1:0]    err_ovf,
  output logic                 err_timeout
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 2;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CAPTURE, S_SOP, S_DATA, S_EOP, S_DONE
  } state_t;

  state_t              state_q;
  logic                sf_q, sf_prev_q;
  logic [NUM_CH-1:0]   rd_sop_q;
  logic                out_sop_q, out_vld_q, out_eop_q;
  logic                drain_done_q, err_timeout_q;
  logic [2*DW-1:0]     out_data_q;
  logic [2:0]          ch_q;
  logic [CW-1:0]       ptr_q;
  logic [TW-1:0]       tmo_q;
  logic [CW-1:0]       cnt_q [NUM_CH];
  logic [NUM_CH-1:0]   eop_seen_q;
  logic [NUM_CH-1:0]   err_ovf_q;
  logic [DW-1:0]       mem [NUM_CH][MAX_LEN];

  logic                capturing;
  logic                all_eop;
  logic [NUM_CH-1:0]   take;
  logic [NUM_CH-1:0]   wr_en;

  assign capturing = (state_q == S_CAPTURE);
  // A channel whose eop arrives this cycle counts as finished already.
  assign all_eop   = &(eop_seen_q | rd_eop_i);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign take[gi]  = capturing && rd_vld_i[gi] && !eop_seen_q[gi];
    assign wr_en[gi] = take[gi] && (cnt_q[gi] < CW'(MAX_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      eop_seen_q <= '0;
      err_ovf_q  <= '0;
    end else if (state_q == S_DONE) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      eop_seen_q <= '0;
    end else if (capturing) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k])     cnt_q[k] <= cnt_q[k] + CW'(1);
        else if (take[k]) err_ovf_q[k] <= 1'b1;
        if (rd_eop_i[k])  eop_seen_q[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en[k]) mem[k][cnt_q[k][AW-1:0]] <= rd_data_i[k*DW +: DW];
    end
  end

  logic [CW-1:0]   cur_cnt, nxt_ptr, hi_idx;
  logic [DW-1:0]   first_hi, next_hi;
  logic [2*DW-1:0] first_pair, next_pair;

  // Read side: the word pair loaded when a packet starts and the pair after the current beat.
  always_comb begin
    cur_cnt    = cnt_q[ch_q];
    nxt_ptr    = ptr_q + CW'(2);
    hi_idx     = nxt_ptr + CW'(1);
    first_hi   = '0;
    next_hi    = '0;
    if (cur_cnt > CW'(1)) first_hi = mem[ch_q][1];
    if (hi_idx < cur_cnt) next_hi  = mem[ch_q][hi_idx[AW-1:0]];
    first_pair = {first_hi, mem[ch_q][0]};
    next_pair  = {next_hi, mem[ch_q][nxt_ptr[AW-1:0]]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sf_q          <= 1'b0;
      sf_prev_q     <= 1'b0;
      rd_sop_q      <= '0;
      out_sop_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_data_q    <= '0;
      ch_q          <= '0;
      ptr_q         <= '0;
      tmo_q         <= '0;
      drain_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      sf_q         <= save_finish;
      sf_prev_q    <= sf_q;
      rd_sop_q     <= '0;
      drain_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sf_q && !sf_prev_q) begin
            state_q  <= S_REQ;
            rd_sop_q <= '1;
          end
        end
        S_REQ: begin
          state_q <= S_CAPTURE;
          tmo_q   <= '0;
        end
        S_CAPTURE: begin
          tmo_q <= tmo_q + TW'(1);
          if (all_eop || tmo_q == TW'(TIMEOUT - 1)) begin
            if (!all_eop) err_timeout_q <= 1'b1;
            state_q   <= S_SOP;
            out_sop_q <= 1'b1;
            ch_q      <= '0;
          end
        end
        S_SOP: begin
          if (out_rdy) begin
            out_sop_q <= 1'b0;
            if (cur_cnt == '0) begin
              state_q   <= S_EOP;
              out_eop_q <= 1'b1;
            end else begin
              state_q    <= S_DATA;
              out_vld_q  <= 1'b1;
              out_data_q <= first_pair;
              ptr_q      <= '0;
            end
          end
        end
        S_DATA: begin
          if (out_rdy) begin
            if (nxt_ptr >= cur_cnt) begin
              state_q    <= S_EOP;
              out_vld_q  <= 1'b0;
              out_data_q <= '0;
              out_eop_q  <= 1'b1;
            end else begin
              ptr_q      <= nxt_ptr;
              out_data_q <= next_pair;
            end
          end
        end
        S_EOP: begin
          if (out_rdy) begin
            out_eop_q <= 1'b0;
            if (ch_q == 3'(NUM_CH - 1)) begin
              state_q      <= S_DONE;
              drain_done_q <= 1'b1;
            end else begin
              ch_q      <= ch_q + 3'(1);
              state_q   <= S_SOP;
              out_sop_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ch_q    <= '0;
          tmo_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_sop_o    = rd_sop_q;
  assign out_sop     = out_sop_q;
  assign out_vld     = out_vld_q;
  assign out_eop     = out_eop_q;
  assign out_data    = out_data_q;
  assign out_ch      = ch_q;
  assign busy        = (state_q != S_IDLE);
  assign drain_done  = drain_done_q;
  assign err_ovf     = err_ovf_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_npu_result_drain.sv
// Directed bench for npu_result_drain: a table of capture scenarios replayed in a
// loop, a packet scoreboard on the output stream, and a mid-drain reset sequence.
module tb_npu_result_drain;
  localparam int NUM_CH  = 8;
  localparam int DW      = 16;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 save_finish;
  logic [NUM_CH-1:0]    rd_sop_o;
  logic [NUM_CH-1:0]    rd_vld_i;
  logic [NUM_CH-1:0]    rd_eop_i;
  logic [NUM_CH*DW-1:0] rd_data_i;
  logic                 out_sop, out_vld, out_eop, out_rdy;
  logic [2*DW-1:0]      out_data;
  logic [2:0]           out_ch;
  logic                 busy, drain_done, err_timeout;
  logic [NUM_CH-1:0]    err_ovf;

  npu_result_drain #(.NUM_CH(NUM_CH), .DW(DW), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .save_finish(save_finish), .rd_sop_o(rd_sop_o),
    .rd_vld_i(rd_vld_i), .rd_eop_i(rd_eop_i), .rd_data_i(rd_data_i),
    .out_sop(out_sop), .out_vld(out_vld), .out_data(out_data), .out_eop(out_eop),
    .out_ch(out_ch), .out_rdy(out_rdy), .busy(busy), .drain_done(drain_done),
    .err_ovf(err_ovf), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0][7:0]  len;
    logic [NUM_CH-1:0][15:0] base;
    logic [NUM_CH-1:0]       eop_en;
    bit                      rand_rdy;
    logic [NUM_CH-1:0]       exp_ovf;
    bit                      exp_tmo;
  } vec_t;

  typedef struct {
    int          kind;   // 0 sop, 1 data, 2 eop
    int          ch;
    logic [31:0] data;
  } beat_t;

  vec_t  tbl[6];
  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    rdy_rand = 1'b0;
  int    rdsop_cnt = 0;
  int    sop_cyc = 0;
  int    exp_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic        p_sop = 0, p_vld = 0, p_eop = 0, p_rdy = 0;
  logic [31:0] p_data = '0;
  logic [2:0]  p_ch = '0;
  beat_t       mon_e;
  int          mon_kind;

  always @(negedge clk) begin
    if (rd_sop_o != '0) rdsop_cnt++;
    if (mon_en) begin
      if (out_sop || out_vld || out_eop)
        chk("excl", 64'($onehot({out_sop, out_vld, out_eop})), 64'd1);
      if (p_vld && !p_rdy) begin
        chk("vld_hold", out_vld, 1);
        chk("data_hold", out_data, p_data);
      end
      if (p_sop && !p_rdy) chk("sop_hold", {out_sop, out_ch}, {1'b1, p_ch});
      if (p_eop && !p_rdy) chk("eop_hold", out_eop, 1);
      if ((out_sop || out_vld || out_eop) && out_rdy) begin
        mon_kind = out_sop ? 0 : (out_vld ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got kind %0d ch %0d data %0h, expected none", mon_kind, out_ch, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_kind", 64'(mon_kind), 64'(mon_e.kind));
          chk("beat_ch", out_ch, 64'(mon_e.ch));
          if (mon_e.kind == 1) chk("beat_data", out_data, mon_e.data);
        end
      end
      p_sop  = out_sop;
      p_vld  = out_vld;
      p_eop  = out_eop;
      p_rdy  = out_rdy;
      p_data = out_data;
      p_ch   = out_ch;
    end
  end

  task automatic build_exp(input int idx);
    int kept;
    logic [15:0] lo, hi;
    exp_q.delete();
    exp_cycles = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      kept = (int'(tbl[idx].len[k]) > MAX_LEN) ? MAX_LEN : int'(tbl[idx].len[k]);
      exp_q.push_back('{0, k, 32'h0});
      for (int i = 0; i < kept; i += 2) begin
        lo = 16'(tbl[idx].base[k] + 16'(i));
        hi = (i + 1 < kept) ? 16'(tbl[idx].base[k] + 16'(i + 1)) : 16'h0;
        exp_q.push_back('{1, k, {hi, lo}});
      end
      exp_q.push_back('{2, k, 32'h0});
      exp_cycles += 2 + (kept + 1) / 2;
    end
  endtask

  task automatic start_and_feed(input int idx);
    int maxc, waited, len;
    build_exp(idx);
    rdy_rand = tbl[idx].rand_rdy;
    save_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdsop_cnt = 0;
    save_finish = 1'b1;
    @(posedge clk); #1;
    chk("rd_sop_t1", rd_sop_o, 0);
    @(posedge clk); #1;
    chk("rd_sop_t2", rd_sop_o, 8'hFF);
    chk("busy_req", busy, 1);
    @(posedge clk); #1;
    chk("rd_sop_t3", rd_sop_o, 0);
    maxc = 1;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(tbl[idx].len[k]) > maxc) maxc = int'(tbl[idx].len[k]);
    for (int c = 0; c < maxc; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        len = int'(tbl[idx].len[k]);
        rd_vld_i[k] = (c < len);
        rd_data_i[k*DW +: DW] = 16'(tbl[idx].base[k] + 16'(c));
        rd_eop_i[k] = tbl[idx].eop_en[k] && ((len == 0 && c == 0) || (len != 0 && c == len - 1));
      end
      if (c == 1) save_finish = 1'b0;
      if (c == 2) save_finish = 1'b1;
      @(posedge clk); #1;
    end
    rd_vld_i = '0;
    rd_eop_i = '0;
    rd_data_i = '0;
    if (!tbl[idx].exp_tmo) begin
      chk("sop_latency", out_sop, 1);
    end else begin
      waited = maxc;
      while (!out_sop && waited < TIMEOUT + 100) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("timeout_cycles", 64'(waited), 64'(TIMEOUT));
    end
    sop_cyc = cyc;
  endtask

  task automatic finish_run(input int idx);
    int waited;
    waited = 0;
    while (!drain_done && waited < 4000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_done_seen", drain_done, 1);
    if (!tbl[idx].rand_rdy) chk("drain_cycles", 64'(cyc - sop_cyc), 64'(exp_cycles));
    chk("queue_empty", 64'(exp_q.size()), 0);
    chk("err_ovf", err_ovf, tbl[idx].exp_ovf);
    chk("err_timeout", err_timeout, tbl[idx].exp_tmo);
    @(posedge clk); #1;
    chk("drain_pulse", drain_done, 0);
    chk("busy_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_sop_count", 64'(rdsop_cnt), 1);
    $display("case %0d drained: checks=%0d errors=%0d", idx, checks, errors);
    rdy_rand = 1'b0;
  endtask

  initial begin
    int bp_len[8];
    int waited;
    bp_len = '{1, 2, 5, 8, 0, 7, 3, 6};
    rst = 1'b1;
    save_finish = 1'b0;
    rd_vld_i = '0;
    rd_eop_i = '0;
    rd_data_i = '0;

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        tbl[t].len[k]  = 8'd4;
        tbl[t].base[k] = 16'(k * 16);
      end
      tbl[t].eop_en   = 8'hFF;
      tbl[t].rand_rdy = 1'b0;
      tbl[t].exp_ovf  = 8'h00;
      tbl[t].exp_tmo  = 1'b0;
    end
    tbl[1].len[2] = 8'd3;
    tbl[1].base[2] = 16'h000A;
    tbl[1].len[4] = 8'd0;
    tbl[2].rand_rdy = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      tbl[2].len[k]  = 8'(bp_len[k]);
      tbl[2].base[k] = 16'(k * 256 + 64);
    end
    tbl[3].len[5]  = 8'(MAX_LEN + 2);
    tbl[3].base[5] = 16'h5000;
    tbl[3].exp_ovf = 8'h20;
    tbl[4].eop_en  = 8'h7F;
    tbl[4].len[7]  = 8'd5;
    tbl[4].base[7] = 16'h7700;
    tbl[4].exp_ovf = 8'h20;
    tbl[4].exp_tmo = 1'b1;

    #12;
    chk("rst_outputs", {out_sop, out_vld, out_eop, out_data, out_ch, rd_sop_o}, 0);
    chk("rst_status", {busy, drain_done, err_ovf, err_timeout}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int t = 0; t < 5; t++) begin
      start_and_feed(t);
      finish_run(t);
    end

    // Reset in the middle of the data phase, then a clean pass.
    start_and_feed(0);
    waited = 0;
    while (!out_vld && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reached_data", out_vld, 1);
    @(posedge clk);
    mon_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {out_sop, out_vld, out_eop, out_data, out_ch, rd_sop_o, drain_done}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", {err_ovf, err_timeout}, 0);
    @(posedge clk); #1;
    chk("rst_hold_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    p_sop = 0; p_vld = 0; p_eop = 0; p_rdy = 0;
    mon_en = 1'b1;
    start_and_feed(5);
    finish_run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
